// File: rtl/seg_display_scan_if.sv
// Bundle between the datapath observation outputs and the 7-segment scanner.
// The master side (datapath / board I/O) supplies the sources, button and
// freeze switch; the slave side (the scanner) returns the display drive and
// the current source index.
interface seg_display_scan_if;
    logic        btn_next;
    logic        freeze;
    logic [31:0] leddata;
    logic [31:0] clk_num;
    logic [31:0] no_branch_num;
    logic [31:0] branch_num;
    logic [31:0] bub_num;
    logic [31:0] loaduse_num;
    logic [31:0] led_data_out;
    logic [31:0] resultmem;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [2:0]  src_idx;

    modport master (
        output btn_next, freeze,
        output leddata, clk_num, no_branch_num, branch_num,
        output bub_num, loaduse_num, led_data_out, resultmem,
        input  an, seg, dp, src_idx
    );

    modport slave (
        input  btn_next, freeze,
        input  leddata, clk_num, no_branch_num, branch_num,
        input  bub_num, loaduse_num, led_data_out, resultmem,
        output an, seg, dp, src_idx
    );
endinterface

// File: rtl/seg_display_scan.sv
// Eight-digit multiplexed hex display of one of eight 32-bit observation
// sources. A debounced push-button steps through the sources; the chosen
// source is snapshotted at each frame start so a frame never tears.
module seg_display_scan #(
    parameter int SCAN_DIV   = 100000,
    parameter int DEB_CYCLES = 1000000
) (
    input logic               clk,
    input logic               rst,
    seg_display_scan_if.slave bus
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEB_CYCLES);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic [DIV_W-1:0] div;
    logic             tick;
    logic [2:0]       digit;
    logic [2:0]       dn;
    logic [31:0]      snap;
    logic [31:0]      snap_next;
    logic [31:0]      src_sel;
    logic [7:0]       an_r;
    logic [6:0]       seg_r;
    logic             dp_r;
    logic             sync1;
    logic             bs;
    logic             btn_db;
    logic [DEB_W-1:0] cnt;
    logic [2:0]       src_idx_r;

    // Active-low segment patterns {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex7seg(input logic [3:0] n);
        case (n)
            4'h0: hex7seg = 7'h40;
            4'h1: hex7seg = 7'h79;
            4'h2: hex7seg = 7'h24;
            4'h3: hex7seg = 7'h30;
            4'h4: hex7seg = 7'h19;
            4'h5: hex7seg = 7'h12;
            4'h6: hex7seg = 7'h02;
            4'h7: hex7seg = 7'h78;
            4'h8: hex7seg = 7'h00;
            4'h9: hex7seg = 7'h10;
            4'hA: hex7seg = 7'h08;
            4'hB: hex7seg = 7'h03;
            4'hC: hex7seg = 7'h46;
            4'hD: hex7seg = 7'h21;
            4'hE: hex7seg = 7'h06;
            default: hex7seg = 7'h0E;
        endcase
    endfunction

    assign tick = (div == DIV_LAST);
    assign dn   = digit + 3'd1;

    // Pick the live source and decide what the snapshot becomes on this tick,
    // so the digit-0 segments can show a value captured on the same edge.
    always_comb begin
        src_sel = bus.leddata;
        case (src_idx_r)
            3'd0: src_sel = bus.leddata;
            3'd1: src_sel = bus.clk_num;
            3'd2: src_sel = bus.no_branch_num;
            3'd3: src_sel = bus.branch_num;
            3'd4: src_sel = bus.bub_num;
            3'd5: src_sel = bus.loaduse_num;
            3'd6: src_sel = bus.led_data_out;
            default: src_sel = bus.resultmem;
        endcase
        snap_next = snap;
        if (dn == 3'd0 && !bus.freeze) begin
            snap_next = src_sel;
        end
    end

    // Digit-slot divider: one tick every SCAN_DIV cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Advance to the next digit on each tick and register its drive pattern.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit <= 3'd7;
            snap  <= '0;
            an_r  <= 8'hFF;
            seg_r <= 7'h7F;
            dp_r  <= 1'b1;
        end else if (tick) begin
            digit <= dn;
            snap  <= snap_next;
            an_r  <= ~(8'b1 << dn);
            seg_r <= hex7seg(snap_next[{dn, 2'b00} +: 4]);
            dp_r  <= ~((dn == 3'd7) && bus.freeze);
        end
    end

    // Two-flop synchronizer for the asynchronous push-button.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            bs    <= 1'b0;
        end else begin
            sync1 <= bus.btn_next;
            bs    <= sync1;
        end
    end

    // Accept a button level only after DEB_CYCLES unbroken differing cycles;
    // an accepted press steps the source index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            btn_db    <= 1'b0;
            src_idx_r <= 3'd0;
        end else if (bs == btn_db) begin
            cnt <= '0;
        end else if (cnt == DEB_LAST) begin
            cnt    <= '0;
            btn_db <= bs;
            if (bs) begin
                src_idx_r <= src_idx_r + 3'd1;
            end
        end else begin
            cnt <= cnt + DEB_W'(1);
        end
    end

    assign bus.an      = an_r;
    assign bus.seg     = seg_r;
    assign bus.dp      = dp_r;
    assign bus.src_idx = src_idx_r;
endmodule

// File: tb/tb_seg_display_scan.sv
// Scoreboard bench for seg_display_scan: each scenario pushes the display
// patterns it expects and pops one per digit tick.
module tb_seg_display_scan;
    localparam int SCAN_DIV   = 4;
    localparam int DEB_CYCLES = 8;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [2:0] digit;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic [2:0] exp_src = 3'd0;
    exp_t exp_q[$];

    seg_display_scan_if bus ();

    seg_display_scan #(
        .SCAN_DIV  (SCAN_DIV),
        .DEB_CYCLES(DEB_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Safety net in case something stalls the sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exhausted, got no summary, want one");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic next_tick();
        do step(1); while (cyc % SCAN_DIV != 0);
    endtask

    task automatic goto_digit(input int d);
        do next_tick(); while ((((cyc / SCAN_DIV) - 1) % 8) != d);
    endtask

    task automatic push_frame(input logic [31:0] v, input int first, input int last,
                              input logic frozen);
        exp_t e;
        for (int d = first; d <= last; d++) begin
            e.an    = ~(8'b1 << d);
            e.seg   = hex7(v[4*d +: 4]);
            e.dp    = (d == 7 && frozen) ? 1'b0 : 1'b1;
            e.digit = 3'(d);
            exp_q.push_back(e);
        end
    endtask

    task automatic press(input int hold);
        bus.btn_next = 1'b1;
        step(hold);
        bus.btn_next = 1'b0;
        step(15);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.an !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL reset_an: got %h want ff", bus.an);
        end
        checks++;
        if (bus.seg !== 7'h7F) begin
            failures++;
            $display("[TB] FAIL reset_seg: got %h want 7f", bus.seg);
        end
        checks++;
        if (bus.dp !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_dp: got %b want 1", bus.dp);
        end
        checks++;
        if (bus.src_idx !== 3'd0) begin
            failures++;
            $display("[TB] FAIL reset_src_idx: got %0d want 0", bus.src_idx);
        end
        step(2);
        rst = 1'b1;
        cyc = 0;
    endtask

    task automatic test_scan();
        exp_t e;
        for (int i = 1; i < SCAN_DIV; i++) begin
            step(1);
            checks++;
            if (bus.an !== 8'hFF) begin
                failures++;
                $display("[TB] FAIL scan_no_early_tick cycle %0d: got an=%h want ff", i, bus.an);
            end
        end
        push_frame(32'h1234ABCD, 0, 7, 1'b0);
        push_frame(32'h1234ABCD, 0, 0, 1'b0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            next_tick();
            checks++;
            if (bus.an !== e.an || bus.seg !== e.seg || bus.dp !== e.dp) begin
                failures++;
                $display("[TB] FAIL scan digit%0d: got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                         e.digit, bus.an, bus.seg, bus.dp, e.an, e.seg, e.dp);
            end
        end
        step(2);
        checks++;
        if (bus.an !== 8'hFE || bus.seg !== 7'h21) begin
            failures++;
            $display("[TB] FAIL scan_hold: got an=%h seg=%h want an=fe seg=21", bus.an, bus.seg);
        end
    endtask

    task automatic test_debounce();
        bus.btn_next = 1'b1;
        step(DEB_CYCLES + 1);
        checks++;
        if (bus.src_idx !== exp_src) begin
            failures++;
            $display("[TB] FAIL debounce_early: got %0d want %0d", bus.src_idx, exp_src);
        end
        step(1);
        exp_src = exp_src + 3'd1;
        checks++;
        if (bus.src_idx !== exp_src) begin
            failures++;
            $display("[TB] FAIL debounce_accept: got %0d want %0d", bus.src_idx, exp_src);
        end
        step(10);
        bus.btn_next = 1'b0;
        step(15);
        checks++;
        if (bus.src_idx !== exp_src) begin
            failures++;
            $display("[TB] FAIL debounce_release: got %0d want %0d", bus.src_idx, exp_src);
        end
        press(5);
        checks++;
        if (bus.src_idx !== exp_src) begin
            failures++;
            $display("[TB] FAIL debounce_short: got %0d want %0d", bus.src_idx, exp_src);
        end
        for (int g = 0; g < 2; g++) begin
            bus.btn_next = 1'b1;
            step(6);
            bus.btn_next = 1'b0;
            step(1);
        end
        bus.btn_next = 1'b1;
        step(6);
        checks++;
        if (bus.src_idx !== exp_src) begin
            failures++;
            $display("[TB] FAIL debounce_glitch_restart: got %0d want %0d", bus.src_idx, exp_src);
        end
        step(10);
        bus.btn_next = 1'b0;
        step(15);
        exp_src = exp_src + 3'd1;
        checks++;
        if (bus.src_idx !== exp_src) begin
            failures++;
            $display("[TB] FAIL debounce_glitch_single: got %0d want %0d", bus.src_idx, exp_src);
        end
    endtask

    task automatic test_press_wrap();
        for (int p = 0; p < 8; p++) begin
            press(12);
            exp_src = exp_src + 3'd1;
            checks++;
            if (bus.src_idx !== exp_src) begin
                failures++;
                $display("[TB] FAIL press_wrap %0d: got %0d want %0d", p, bus.src_idx, exp_src);
            end
        end
    endtask

    task automatic test_source_select();
        exp_t e;
        bus.clk_num = 32'h00000007;
        while (exp_src != 3'd1) begin
            press(12);
            exp_src = exp_src + 3'd1;
            checks++;
            if (bus.src_idx !== exp_src) begin
                failures++;
                $display("[TB] FAIL source_press: got %0d want %0d", bus.src_idx, exp_src);
            end
        end
        goto_digit(7);
        push_frame(32'h00000007, 0, 7, 1'b0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            next_tick();
            checks++;
            if (bus.an !== e.an || bus.seg !== e.seg || bus.dp !== e.dp) begin
                failures++;
                $display("[TB] FAIL source_frame digit%0d: got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                         e.digit, bus.an, bus.seg, bus.dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_freeze();
        exp_t e;
        bus.freeze  = 1'b1;
        bus.clk_num = 32'hFFFFFFFF;
        push_frame(32'h00000007, 0, 7, 1'b1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            next_tick();
            checks++;
            if (bus.an !== e.an || bus.seg !== e.seg || bus.dp !== e.dp) begin
                failures++;
                $display("[TB] FAIL freeze_hold digit%0d: got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                         e.digit, bus.an, bus.seg, bus.dp, e.an, e.seg, e.dp);
            end
        end
        bus.freeze = 1'b0;
        push_frame(32'hFFFFFFFF, 0, 7, 1'b0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            next_tick();
            checks++;
            if (bus.an !== e.an || bus.seg !== e.seg || bus.dp !== e.dp) begin
                failures++;
                $display("[TB] FAIL freeze_resume digit%0d: got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                         e.digit, bus.an, bus.seg, bus.dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bus.clk_num = 32'h89ABCDEF;
        push_frame(32'h89ABCDEF, 0, 3, 1'b0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            next_tick();
            checks++;
            if (bus.an !== e.an || bus.seg !== e.seg || bus.dp !== e.dp) begin
                failures++;
                $display("[TB] FAIL midframe_before digit%0d: got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                         e.digit, bus.an, bus.seg, bus.dp, e.an, e.seg, e.dp);
            end
        end
        bus.clk_num = 32'h01234567;
        push_frame(32'h89ABCDEF, 4, 7, 1'b0);
        push_frame(32'h01234567, 0, 7, 1'b0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            next_tick();
            checks++;
            if (bus.an !== e.an || bus.seg !== e.seg || bus.dp !== e.dp) begin
                failures++;
                $display("[TB] FAIL midframe_after digit%0d: got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                         e.digit, bus.an, bus.seg, bus.dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_reset_midframe();
        exp_t e;
        goto_digit(2);
        step(1);
        #3;
        rst = 1'b0;
        #1;
        exp_src = 3'd0;
        checks++;
        if (bus.an !== 8'hFF || bus.seg !== 7'h7F || bus.dp !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_display: got an=%h seg=%h dp=%b want an=ff seg=7f dp=1",
                     bus.an, bus.seg, bus.dp);
        end
        checks++;
        if (bus.src_idx !== exp_src) begin
            failures++;
            $display("[TB] FAIL midreset_src_idx: got %0d want 0", bus.src_idx);
        end
        step(1);
        rst = 1'b1;
        cyc = 0;
        for (int i = 1; i < SCAN_DIV; i++) begin
            step(1);
            checks++;
            if (bus.an !== 8'hFF) begin
                failures++;
                $display("[TB] FAIL midreset_no_early_tick cycle %0d: got an=%h want ff", i, bus.an);
            end
        end
        push_frame(32'h1234ABCD, 0, 7, 1'b0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            next_tick();
            checks++;
            if (bus.an !== e.an || bus.seg !== e.seg || bus.dp !== e.dp) begin
                failures++;
                $display("[TB] FAIL midreset_frame digit%0d: got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                         e.digit, bus.an, bus.seg, bus.dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    initial begin
        bus.btn_next      = 1'b0;
        bus.freeze        = 1'b0;
        bus.leddata       = 32'h1234ABCD;
        bus.clk_num       = 32'hDEADBEEF;
        bus.no_branch_num = 32'h22222222;
        bus.branch_num    = 32'h33333333;
        bus.bub_num       = 32'h44444444;
        bus.loaduse_num   = 32'h55555555;
        bus.led_data_out  = 32'h66666666;
        bus.resultmem     = 32'h77777777;
        $display("[TB] starting seg_display_scan bench");
        test_reset();
        test_scan();
        test_debounce();
        test_press_wrap();
        test_source_select();
        test_freeze();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
